// File: rtl/sa_mm_engine.sv
// Output-stationary systolic matrix-multiply engine with held result.
// Define SA_MM_SATURATE_EN to clamp results; otherwise they wrap.
module sa_mm_engine #(
  parameter int D_W    = 8,
  parameter int FRAC_W = 5,
  parameter int SA_R   = 16,
  parameter int SA_C   = 16,
  parameter int M_DIM  = 16
) (
  input  logic                                  I_CLK,
  input  logic                                  I_ASYN_RSTN,
  input  logic                                  I_SYNC_RSTN,
  input  logic                                  I_START,
  input  logic [0:SA_R-1][0:M_DIM-1][D_W-1:0]   I_MAT_1,
  input  logic [0:M_DIM-1][0:SA_C-1][D_W-1:0]   I_MAT_2,
  output logic                                  O_VLD,
  output logic                                  O_PE_SHIFT,
  output logic                                  O_BUSY,
  output logic [0:SA_R-1][0:SA_C-1][D_W-1:0]    O_RESULT
);

  localparam int T     = M_DIM + SA_R + SA_C - 2;
  localparam int CNT_W = $clog2(T + 1);
  localparam int KW    = (M_DIM > 1) ? $clog2(M_DIM) : 1;
  localparam int P_W   = 2 * D_W;
  localparam int ACC_W = P_W + KW;

`ifdef SA_MM_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    ACC_W'((2 ** (D_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    ACC_W'(-(2 ** (D_W - 1)));
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_NORM,
    S_DONE
  } state_t;

  state_t                                r_state;
  logic [CNT_W-1:0]                      r_cnt;
  logic                                  r_pe_shift;
  logic                                  r_busy;
  logic                                  r_vld;
  logic [0:SA_R-1][0:SA_C-1][D_W-1:0]    r_result;
  logic [0:SA_R-1][0:M_DIM-1][D_W-1:0]   r_mat_a;
  logic [0:M_DIM-1][0:SA_C-1][D_W-1:0]   r_mat_b;

  logic signed [D_W-1:0]   r_a_pe [SA_R][SA_C];
  logic signed [D_W-1:0]   r_b_pe [SA_R][SA_C];
  logic signed [ACC_W-1:0] r_acc  [SA_R][SA_C];

  logic signed [D_W-1:0]   w_a_edge [SA_R];
  logic signed [D_W-1:0]   w_b_edge [SA_C];
  logic [D_W-1:0]          w_res [SA_R][SA_C];
  logic                    w_load;
  logic                    w_run;

  assign w_load = (r_state == S_IDLE) && I_START;
  assign w_run  = (r_state == S_RUN);

  function automatic logic [D_W-1:0] f_reduce(
    input logic signed [ACC_W-1:0] acc
  );
`ifdef SA_MM_SATURATE_EN
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> FRAC_W;
    if (sh > SAT_MAX)
      return SAT_MAX[D_W-1:0];
    else if (sh < SAT_MIN)
      return SAT_MIN[D_W-1:0];
    else
      return sh[D_W-1:0];
`else
    return D_W'(acc >>> FRAC_W);
`endif
  endfunction

  // Skewed feed: row i sees A[i][t-i], column j sees B[t-j][j].
  always_comb begin
    for (int i = 0; i < SA_R; i++) begin
      int k;
      k = int'(r_cnt) - i;
      w_a_edge[i] = '0;
      if (k >= 0 && k < M_DIM)
        w_a_edge[i] = r_mat_a[i][KW'(k)];
    end
    for (int j = 0; j < SA_C; j++) begin
      int k;
      k = int'(r_cnt) - j;
      w_b_edge[j] = '0;
      if (k >= 0 && k < M_DIM)
        w_b_edge[j] = r_mat_b[KW'(k)][j];
    end
  end

  always_comb begin
    for (int i = 0; i < SA_R; i++)
      for (int j = 0; j < SA_C; j++)
        w_res[i][j] = f_reduce(r_acc[i][j]);
  end

  genvar gi, gj;
  for (gi = 0; gi < SA_R; gi++) begin : g_row
    for (gj = 0; gj < SA_C; gj++) begin : g_col
      logic signed [D_W-1:0] w_a_in;
      logic signed [D_W-1:0] w_b_in;
      logic signed [P_W-1:0] w_prod;

      if (gj == 0) begin : g_a_edge
        assign w_a_in = w_a_edge[gi];
      end else begin : g_a_pass
        assign w_a_in = r_a_pe[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign w_b_in = w_b_edge[gj];
      end else begin : g_b_pass
        assign w_b_in = r_b_pe[gi-1][gj];
      end

      assign w_prod = w_a_in * w_b_in;

      always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
          r_a_pe[gi][gj] <= '0;
          r_b_pe[gi][gj] <= '0;
          r_acc[gi][gj]  <= '0;
        end else if (!I_SYNC_RSTN || w_load) begin
          r_a_pe[gi][gj] <= '0;
          r_b_pe[gi][gj] <= '0;
          r_acc[gi][gj]  <= '0;
        end else if (w_run) begin
          r_a_pe[gi][gj] <= w_a_in;
          r_b_pe[gi][gj] <= w_b_in;
          r_acc[gi][gj]  <= r_acc[gi][gj] +
            {{(ACC_W-P_W){w_prod[P_W-1]}}, w_prod};
        end
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pe_shift <= 1'b0;
      r_busy     <= 1'b0;
      r_vld      <= 1'b0;
      r_result   <= '0;
      r_mat_a    <= '0;
      r_mat_b    <= '0;
    end else if (!I_SYNC_RSTN) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pe_shift <= 1'b0;
      r_busy     <= 1'b0;
      r_vld      <= 1'b0;
      r_result   <= '0;
      r_mat_a    <= '0;
      r_mat_b    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (I_START) begin
            r_mat_a    <= I_MAT_1;
            r_mat_b    <= I_MAT_2;
            r_cnt      <= '0;
            r_pe_shift <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_cnt == CNT_W'(T - 1)) begin
            r_pe_shift <= 1'b0;
            r_state    <= S_NORM;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_NORM: begin
          for (int i = 0; i < SA_R; i++)
            for (int j = 0; j < SA_C; j++)
              r_result[i][j] <= w_res[i][j];
          r_vld   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign O_VLD      = r_vld;
  assign O_PE_SHIFT = r_pe_shift;
  assign O_BUSY     = r_busy;
  assign O_RESULT   = r_result;

endmodule

// File: tb/tb_sa_mm_engine.sv
// Scoreboard bench for sa_mm_engine against a plain-arithmetic matrix model.
// Honours SA_MM_SATURATE_EN the same way the design does.
module tb_sa_mm_engine;

  localparam int D_W    = 8;
  localparam int FRAC_W = 5;
  localparam int SA_R   = 16;
  localparam int SA_C   = 16;
  localparam int M_DIM  = 16;
  localparam int T      = M_DIM + SA_R + SA_C - 2;

  typedef logic [0:SA_R-1][0:M_DIM-1][D_W-1:0] mat_a_t;
  typedef logic [0:M_DIM-1][0:SA_C-1][D_W-1:0] mat_b_t;
  typedef logic [0:SA_R-1][0:SA_C-1][D_W-1:0]  mat_c_t;

  logic   clk;
  logic   rst_n;
  logic   sync_n;
  logic   start;
  mat_a_t mat1;
  mat_b_t mat2;
  logic   vld;
  logic   pe_shift;
  logic   busy;
  mat_c_t result;

  int     n_chk;
  int     n_pass;
  mat_c_t exp_q[$];
  mat_c_t zero_m;
  logic   prev_vld;
  mat_c_t held;
  mat_c_t mon_exp;

  sa_mm_engine #(
    .D_W(D_W), .FRAC_W(FRAC_W), .SA_R(SA_R),
    .SA_C(SA_C), .M_DIM(M_DIM)
  ) dut (
    .I_CLK      (clk),
    .I_ASYN_RSTN(rst_n),
    .I_SYNC_RSTN(sync_n),
    .I_START    (start),
    .I_MAT_1    (mat1),
    .I_MAT_2    (mat2),
    .O_VLD      (vld),
    .O_PE_SHIFT (pe_shift),
    .O_BUSY     (busy),
    .O_RESULT   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, got, exp);
  endtask

  task automatic cmp_mat(input string name, input mat_c_t got,
                         input mat_c_t exp);
    int bi, bj;
    bi = -1;
    bj = -1;
    n_chk++;
    for (int i = 0; i < SA_R; i++)
      for (int j = 0; j < SA_C; j++)
        if (bi < 0 && got[i][j] !== exp[i][j]) begin
          bi = i;
          bj = j;
        end
    if (bi < 0) n_pass++;
    else $display("FAIL %s: element [%0d][%0d] got %02h, required %02h",
                  name, bi, bj, got[bi][bj], exp[bi][bj]);
  endtask

  // Reference: C = (A*B) >>> FRAC_W, then clamp or keep low bits.
  function automatic mat_c_t model(input mat_a_t a, input mat_b_t b);
    mat_c_t r;
    for (int i = 0; i < SA_R; i++)
      for (int j = 0; j < SA_C; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < M_DIM; k++)
          s += int'($signed(a[i][k])) * int'($signed(b[k][j]));
        s = s >>> FRAC_W;
`ifdef SA_MM_SATURATE_EN
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`endif
        r[i][j] = D_W'(s);
      end
    return r;
  endfunction

  function automatic mat_a_t rand_a();
    mat_a_t r;
    for (int i = 0; i < SA_R; i++)
      for (int k = 0; k < M_DIM; k++)
        r[i][k] = D_W'($urandom_range(255));
    return r;
  endfunction

  function automatic mat_b_t rand_b();
    mat_b_t r;
    for (int k = 0; k < M_DIM; k++)
      for (int j = 0; j < SA_C; j++)
        r[k][j] = D_W'($urandom_range(255));
    return r;
  endfunction

  always @(negedge clk) begin
    if (vld && !prev_vld) begin
      if (exp_q.size() == 0) begin
        check("unexpected_vld", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        cmp_mat("result", result, mon_exp);
      end
      held <= result;
    end else if (vld && prev_vld) begin
      cmp_mat("hold", result, held);
    end
    prev_vld <= vld;
  end

  task automatic run_op(input mat_a_t a, input mat_b_t b,
                        input bit timing, input bit inject);
    int n, sh;
    @(negedge clk);
    mat1 = a;
    mat2 = b;
    start = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    mat1 = rand_a();
    mat2 = rand_b();
    n = 0;
    sh = 0;
    while (!vld && n < 200) begin
      if (pe_shift) sh++;
      if (inject && n == 5) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end
    check("no_timeout", int'(n < 200), 1);
    if (timing) begin
      check("latency", n, T + 1);
      check("pe_shift_cycles", sh, T);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    sync_n = 1'b0;
    @(posedge clk);
    #1;
    sync_n = 1'b1;
    check("clr_vld", int'(vld), 0);
    check("clr_busy", int'(busy), 0);
    check("clr_shift", int'(pe_shift), 0);
    cmp_mat("clr_result", result, zero_m);
  endtask

  initial begin
    mat_a_t a;
    mat_b_t b;
    n_chk = 0;
    n_pass = 0;
    zero_m = '0;
    prev_vld = 1'b0;
    held = '0;
    rst_n = 1'b0;
    sync_n = 1'b1;
    start = 1'b0;
    mat1 = '0;
    mat2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", int'(vld), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_shift", int'(pe_shift), 0);
    cmp_mat("rst_result", result, zero_m);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < SA_R; i++)
      for (int k = 0; k < M_DIM; k++)
        a[i][k] = D_W'(i + k);
    b = '0;
    for (int k = 0; k < M_DIM; k++) b[k][k] = 8'h20;
    run_op(a, b, 1'b1, 1'b0);
    cmp_mat("ident_eq_a", result, mat_c_t'(a));

    do_clear();
    a = {(SA_R*M_DIM){8'h20}};
    b = '0;
    for (int k = 0; k < M_DIM; k++) b[k][k] = 8'h08;
    run_op(a, b, 1'b1, 1'b0);
    check("scale_elem", int'(result[3][5]), 8);

    @(negedge clk);
    start = 1'b1;
    mat1 = rand_a();
    mat2 = rand_b();
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_start_busy", int'(busy), 0);
    check("done_start_shift", int'(pe_shift), 0);
    check("done_start_vld", int'(vld), 1);

    do_clear();
    a = {(SA_R*M_DIM){8'h7F}};
    b = {(M_DIM*SA_C){8'h7F}};
    run_op(a, b, 1'b0, 1'b0);
`ifdef SA_MM_SATURATE_EN
    check("ovf_elem", int'(result[7][9]), 8'h7F);
`else
    check("ovf_elem", int'(result[7][9]), 8'h80);
`endif

    do_clear();
    a = '0;
    b = '0;
    a[0][0] = 8'hFF;
    b[0][0] = 8'h01;
    run_op(a, b, 1'b0, 1'b0);
    check("neg_floor", int'(result[0][0]), 8'hFF);
    check("neg_other", int'(result[1][1]), 0);

    do_clear();
    @(negedge clk);
    start = 1'b1;
    mat1 = rand_a();
    mat2 = rand_b();
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_busy_pre", int'(busy), 1);
    @(negedge clk);
    sync_n = 1'b0;
    @(posedge clk);
    #1;
    sync_n = 1'b1;
    check("abort_busy", int'(busy), 0);
    check("abort_shift", int'(pe_shift), 0);
    cmp_mat("abort_result", result, zero_m);
    repeat (60) @(posedge clk);
    #1;
    check("abort_no_vld", int'(vld), 0);
    run_op(rand_a(), rand_b(), 1'b1, 1'b0);

    do_clear();
    run_op(rand_a(), rand_b(), 1'b1, 1'b1);

    do_clear();
    @(negedge clk);
    sync_n = 1'b0;
    start = 1'b1;
    mat1 = rand_a();
    mat2 = rand_b();
    @(posedge clk);
    #1;
    sync_n = 1'b1;
    start = 1'b0;
    check("clr_start_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check("clr_start_idle", int'(busy | pe_shift), 0);

    @(negedge clk);
    start = 1'b1;
    mat1 = rand_a();
    mat2 = rand_b();
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_shift", int'(pe_shift), 0);
    check("arst_vld", int'(vld), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("arst_no_vld", int'(vld), 0);

    for (int r = 0; r < 4; r++) begin
      run_op(rand_a(), rand_b(), 1'b1, 1'b0);
      do_clear();
    end

    repeat (2) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sa_mm_engine.md
# sa_mm_engine

Systolic-array matrix-multiply engine that answers the attention sequencer's SA request interface. It latches two signed fixed-point operand matrices on a start pulse and computes their product in an output-stationary SA_R×SA_C PE grid. It returns a rescaled D_W-bit result matrix with a held valid flag. The flag stays asserted until the sequencer issues a synchronous clear, so one engine can serve the Q·Kᵀ, scale and P·V passes in turn.

## Interface
- D_W, 8: operand/result width, signed two's complement, format s.2.5.
- FRAC_W, 5: fractional bits of D_W format.
- SA_R, 16: result rows / PE rows.
- SA_C, 16: result columns / PE columns.
- M_DIM, 16: inner (reduction) dimension.
- I_CLK  in  1  single clock, rising edge.
- I_ASYN_RSTN  in  1  reset, asynchronous, active-low.
- I_SYNC_RSTN  in  1  synchronous clear, active-low (sequencer's clear strobe).
- I_START  in  1  start request, sampled only in IDLE.
- I_MAT_1  in  [0:SA_R-1][0:M_DIM-1]×D_W  left operand A.
- I_MAT_2  in  [0:M_DIM-1][0:SA_C-1]×D_W  right operand B.
- O_VLD  out  1  result valid, level, held until clear.
- O_PE_SHIFT  out  1  high while operands are shifting through the array.
- O_BUSY  out  1  high in RUN and NORM.
- O_RESULT  out  [0:SA_R-1][0:SA_C-1]×D_W  C = A·B rescaled.

## Operation
- States: IDLE, RUN, NORM, DONE.
- IDLE: I_START=1 latches I_MAT_1/I_MAT_2 into internal operand buffers, zeroes the accumulators and counter, then moves to RUN. Operand ports are don't-care after this edge.
- RUN: T = M_DIM+SA_R+SA_C-2 steps (46 at defaults). At step t, PE(i,j) accumulates A[i][k]·B[k][j] with k = t-i-j when 0 ≤ k < M_DIM. A is fed row-skewed from the left and B column-skewed from the top. After step T-1, go to NORM.
- NORM: each accumulator is arithmetic-shifted right by FRAC_W (floor), then reduced to D_W per Configuration. The result is registered into O_RESULT, O_VLD is set to 1, and the state moves to DONE.
- DONE: O_RESULT and O_VLD are held. I_START is ignored; only a clear leaves DONE.
- Arithmetic: product width 2·D_W. Accumulator width 2·D_W+clog2(M_DIM) (20 bits at defaults), signed, no internal overflow.
- Clear (I_SYNC_RSTN=0) is valid in any state. Next state is IDLE. Accumulators, operand buffers, counter, O_VLD, O_PE_SHIFT, O_BUSY and O_RESULT all go to zero. An in-flight RUN is aborted.
- Clear and I_START asserted in the same cycle: clear wins and the start is dropped.

## Timing
- Reset values (async and sync): O_VLD=0, O_PE_SHIFT=0, O_BUSY=0, O_RESULT all 0, state IDLE.
- Cycle reference: edge E0 samples I_START=1 in IDLE.
- O_PE_SHIFT and O_BUSY go high after E0. O_PE_SHIFT stays high for exactly T cycles and falls after edge E_T.
- O_VLD and O_RESULT update at edge E_(T+1), giving 47 cycles of latency at defaults. O_BUSY falls at the same edge.
- O_RESULT changes only at the NORM edge or on clear, never while O_VLD=1.
- Back-to-back operation: clear for one cycle, then I_START. The earliest I_START is sampled on the edge after the clear edge.
- Async reset mid-RUN: immediate return to IDLE with reset values. No partial result is emitted.

## Configuration
- SA_MM_SATURATE_EN defined: the shifted accumulator is clamped to [-2^(D_W-1), 2^(D_W-1)-1], i.e. 0x80..0x7F.
- SA_MM_SATURATE_EN undefined: the low D_W bits of the shifted accumulator are taken (wrap-around), with no clamp logic.

## Test plan
- Identity product: A = Q pattern (Q[i][j]=i+j), B = identity (diagonal 0x20 = 1.0) -> O_RESULT == A, O_VLD high 47 cycles after start.
- Scale pass: A all 0x20, B diagonal 0x08 (0.25) -> every O_RESULT element 0x08. O_PE_SHIFT high exactly 46 cycles.
- Overflow: A,B all 0x7F (M_DIM=16) -> accumulator 258064, shifted 0x1F80. With SA_MM_SATURATE_EN result 0x7F everywhere; without it, 0x80 everywhere.
- Negative floor: A[0][0]=0xFF (−1/32), B[0][0]=0x01, rest 0 -> O_RESULT[0][0]=0xFF. All other elements 0.
- Clear mid-RUN at step 10 -> O_BUSY/O_PE_SHIFT drop next cycle, O_VLD never rises, O_RESULT stays 0. A subsequent start produces the correct full result.
- I_START pulsed in DONE and in RUN -> ignored, O_RESULT unchanged. Clear and start in the same cycle -> engine stays IDLE.
